// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU pipeline buses and the MEM-stage FSM.
package cpu_pkg;

    localparam int EXE_MEM_W = 106;
    localparam int MEM_WB_W  = 70;

    // Bit positions inside the EXE->MEM bus, MSB first
    localparam int BIT_INST_LOAD  = 105;
    localparam int BIT_INST_STORE = 104;
    localparam int BIT_LS_WORD    = 103;
    localparam int BIT_LB_SIGN    = 102;
    localparam int STORE_DATA_LSB = 70;
    localparam int EXE_RESULT_LSB = 38;
    localparam int BIT_WEN        = 37;
    localparam int WDEST_LSB      = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        DONE
    } mem_state_t;

    function automatic logic [3:0] byte_lane_wen(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte of a RAM word and sign/zero extends it; words pass unchanged.
module load_align (
    input  logic [31:0] dm_rdata,
    input  logic [1:0]  addr_lo,
    input  logic        ls_word,
    input  logic        lb_sign,
    output logic [31:0] load_data
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = dm_rdata[8*addr_lo +: 8];
        if (ls_word)
            load_data = dm_rdata;
        else if (lb_sign)
            load_data = {{24{byte_sel[7]}}, byte_sel};
        else
            load_data = {24'h000000, byte_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data RAM, aligns loads and builds the MEM->WB bus.
module mem_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 MEM_valid,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
    input  logic [31:0]          dm_rdata,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_wen,
    output logic [31:0]          dm_wdata,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [31:0]          MEM_pc
);

    logic        inst_load;
    logic        inst_store;
    logic        ls_word;
    logic        lb_sign;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] pc;

    assign inst_load  = EXE_MEM_bus_r[BIT_INST_LOAD];
    assign inst_store = EXE_MEM_bus_r[BIT_INST_STORE];
    assign ls_word    = EXE_MEM_bus_r[BIT_LS_WORD];
    assign lb_sign    = EXE_MEM_bus_r[BIT_LB_SIGN];
    assign store_data = EXE_MEM_bus_r[STORE_DATA_LSB +: 32];
    assign exe_result = EXE_MEM_bus_r[EXE_RESULT_LSB +: 32];
    assign wen        = EXE_MEM_bus_r[BIT_WEN];
    assign wdest      = EXE_MEM_bus_r[WDEST_LSB +: 5];
    assign pc         = EXE_MEM_bus_r[31:0];

    mem_state_t  state;
    mem_state_t  state_next;
    logic [31:0] load_data;
    logic [31:0] load_r;
    logic [31:0] mem_result;

    load_align u_load_align (
        .dm_rdata  (dm_rdata),
        .addr_lo   (exe_result[1:0]),
        .ls_word   (ls_word),
        .lb_sign   (lb_sign),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!MEM_valid) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      state_next = inst_load ? LOAD_WAIT : DONE;
                LOAD_WAIT: state_next = DONE;
                DONE:      state_next = DONE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // The write pulse is confined to the first cycle so a store hits the RAM exactly once
    always_comb begin
        MEM_over = 1'b0;
        dm_wen   = 4'h0;
        if (resetn && MEM_valid) begin
            MEM_over = ((state == IDLE) && !inst_load) || (state == DONE);
            if ((state == IDLE) && inst_store && !inst_load)
                dm_wen = ls_word ? 4'hF : byte_lane_wen(exe_result[1:0]);
        end
    end

    // RAM data for the address presented in IDLE is on dm_rdata during LOAD_WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            load_r <= 32'h0;
        else if ((state == LOAD_WAIT) && MEM_valid)
            load_r <= load_data;
    end

    assign dm_addr    = {exe_result[31:2], 2'b00};
    assign dm_wdata   = ls_word ? store_data : {4{store_data[7:0]}};
    assign mem_result = inst_load ? load_r : exe_result;
    assign MEM_WB_bus = {wen, wdest, mem_result, pc};
    assign MEM_pc     = pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a bench-owned synchronous RAM and a cycle-level model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         MEM_valid = 1'b0;
    logic [105:0] EXE_MEM_bus_r;
    logic [31:0]  dm_rdata = 32'h0;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_wdata;
    logic         MEM_over;
    logic [69:0]  MEM_WB_bus;
    logic [31:0]  MEM_pc;

    logic        b_load = 1'b0, b_store = 1'b0, b_word = 1'b0, b_sign = 1'b0, b_wen = 1'b0;
    logic [31:0] b_sdata = 32'h0, b_eres = 32'h0, b_pc = 32'h0;
    logic [4:0]  b_wdest = 5'h0;

    assign EXE_MEM_bus_r = {b_load, b_store, b_word, b_sign, b_sdata, b_eres, b_wen, b_wdest, b_pc};

    mem_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .MEM_valid     (MEM_valid),
        .EXE_MEM_bus_r (EXE_MEM_bus_r),
        .dm_rdata      (dm_rdata),
        .dm_addr       (dm_addr),
        .dm_wen        (dm_wen),
        .dm_wdata      (dm_wdata),
        .MEM_over      (MEM_over),
        .MEM_WB_bus    (MEM_WB_bus),
        .MEM_pc        (MEM_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Synchronous RAM: byte-enabled write, registered read of the presented address
    logic [31:0] ram [256] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (dm_wen[i]) ram[dm_addr[9:2]][8*i +: 8] <= dm_wdata[8*i +: 8];
        dm_rdata <= ram[dm_addr[9:2]];
    end

    int wr_cnt = 0;
    int over_cnt = 0;
    always @(posedge clk) if (dm_wen != 4'h0) wr_cnt <= wr_cnt + 1;
    always @(negedge clk) if (MEM_over) over_cnt <= over_cnt + 1;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input logic word, input logic sgn);
        int unsigned b;
        if (word) return w;
        b = (w >> (8 * a)) & 32'hFF;
        if (sgn && b >= 128) return 32'(b) | 32'hFFFF_FF00;
        return 32'(b);
    endfunction

    // Model: mk = clock edges the current instruction has spent in MEM with reset released
    int          mk = 0;
    logic [31:0] prev = 32'h0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mk   <= 0;
            prev <= 32'h0;
        end else if (!MEM_valid) begin
            mk <= 0;
        end else begin
            if (b_load && mk == 1)
                prev <= model_load(ram[b_eres[9:2]], b_eres[1:0], b_word, b_sign);
            if (mk < 3) mk <= mk + 1;
        end
    end

    logic        exp_over;
    logic [3:0]  exp_wen;
    logic [69:0] exp_bus;
    always @(negedge clk) begin
        exp_over = resetn && MEM_valid && (!b_load || mk >= 2);
        exp_wen  = (resetn && MEM_valid && b_store && !b_load && mk == 0)
                   ? (b_word ? 4'hF : (4'b0001 << b_eres[1:0])) : 4'h0;
        exp_bus  = {b_wen, b_wdest, (b_load ? prev : b_eres), b_pc};
        chk("model_over", 70'(MEM_over), 70'(exp_over));
        chk("model_wen", 70'(dm_wen), 70'(exp_wen));
        chk("model_addr", 70'(dm_addr), 70'({b_eres[31:2], 2'b00}));
        chk("model_bus", MEM_WB_bus, exp_bus);
        chk("model_pc", 70'(MEM_pc), 70'(b_pc));
        if (exp_wen != 4'h0)
            chk("model_wdata", 70'(dm_wdata), 70'(b_word ? b_sdata : {4{b_sdata[7:0]}}));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic ld, input logic st, input logic wd, input logic sg,
                           input logic [31:0] sd, input logic [31:0] er,
                           input logic [4:0] dst, input logic [31:0] p);
        b_load = ld; b_store = st; b_word = wd; b_sign = sg;
        b_sdata = sd; b_eres = er; b_wen = ld | ~st; b_wdest = dst; b_pc = p;
    endtask

    task automatic retire;
        MEM_valid = 1'b0;
        tick();
    endtask

    task automatic run_store(input logic wd, input logic [31:0] addr, input logic [31:0] data);
        int w0;
        w0 = wr_cnt;
        set_bus(1'b0, 1'b1, wd, 1'b0, data, addr, 5'd0, 32'h2000);
        MEM_valid = 1'b1;
        tick(); tick();
        retire();
        chk("store_one_pulse", 70'(wr_cnt - w0), 70'd1);
    endtask

    task automatic run_load(input logic wd, input logic sg, input logic [31:0] addr,
                            input logic [31:0] expv, input string nm);
        set_bus(1'b1, 1'b0, wd, sg, 32'h0, addr, 5'd7, 32'h3000);
        MEM_valid = 1'b1;
        #1 chk({nm, "_over_c0"}, 70'(MEM_over), 70'd0);
        tick();
        #1 chk({nm, "_over_c1"}, 70'(MEM_over), 70'd0);
        tick();
        #1 chk({nm, "_over_c2"}, 70'(MEM_over), 70'd1);
        chk({nm, "_result"}, 70'(MEM_WB_bus[63:32]), 70'(expv));
        tick();
        retire();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int o0;
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        tick(); tick();
        chk("reset_over", 70'(MEM_over), 70'd0);
        chk("reset_wen", 70'(dm_wen), 70'd0);
        resetn = 1'b1;
        tick();

        // ALU result passes straight through in cycle 0
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 5'd5, 32'h1000);
        MEM_valid = 1'b1;
        #1 chk("alu_over_c0", 70'(MEM_over), 70'd1);
        chk("alu_result", 70'(MEM_WB_bus[63:32]), 70'h1234_5678);
        chk("alu_wen_wdest", 70'(MEM_WB_bus[69:64]), 70'({1'b1, 5'd5}));
        chk("alu_dm_wen", 70'(dm_wen), 70'd0);
        tick();
        #1 chk("alu_over_done", 70'(MEM_over), 70'd1);
        retire();

        w0 = wr_cnt;
        set_bus(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h100, 5'd0, 32'h1004);
        MEM_valid = 1'b1;
        #1 chk("sw_wen", 70'(dm_wen), 70'hF);
        chk("sw_addr", 70'(dm_addr), 70'h100);
        chk("sw_wdata", 70'(dm_wdata), 70'hDEAD_BEEF);
        chk("sw_over_c0", 70'(MEM_over), 70'd1);
        tick();
        #1 chk("sw_wen_c1", 70'(dm_wen), 70'd0);
        retire();
        chk("sw_one_pulse", 70'(wr_cnt - w0), 70'd1);
        chk("sw_ram", 70'(ram[8'h40]), 70'hDEAD_BEEF);

        set_bus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'h103, 5'd0, 32'h1008);
        MEM_valid = 1'b1;
        #1 chk("sb_wen", 70'(dm_wen), 70'b1000);
        chk("sb_wdata", 70'(dm_wdata), 70'hABAB_ABAB);
        tick();
        retire();
        chk("sb_ram", 70'(ram[8'h40]), 70'hABAD_BEEF);

        run_store(1'b1, 32'h100, 32'h0080_0000);
        run_store(1'b1, 32'h200, 32'hCAFE_F00D);
        run_store(1'b0, 32'h201, 32'h0000_0055);

        run_load(1'b0, 1'b1, 32'h102, 32'hFFFF_FF80, "lb");
        run_load(1'b0, 1'b0, 32'h102, 32'h0000_0080, "lbu");
        run_load(1'b1, 1'b0, 32'h201, 32'hCAFE_550D, "lw_unaligned");
        run_load(1'b0, 1'b1, 32'h201, 32'h0000_0055, "lb_lane1");
        run_load(1'b0, 1'b0, 32'h102, 32'h0000_0080, "lbu_again");

        // Load abandoned in LOAD_WAIT leaves the previous load result in place
        o0 = over_cnt;
        set_bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 5'd9, 32'h1010);
        MEM_valid = 1'b1;
        tick();
        MEM_valid = 1'b0;
        tick(); tick();
        chk("cancel_no_over", 70'(over_cnt - o0), 70'd0);
        chk("cancel_keep_load", 70'(MEM_WB_bus[63:32]), 70'h0000_0080);

        // Reset during LOAD_WAIT with MEM_valid held high
        w0 = wr_cnt;
        MEM_valid = 1'b1;
        tick();
        resetn = 1'b0;
        #1 chk("rst_over", 70'(MEM_over), 70'd0);
        chk("rst_wen", 70'(dm_wen), 70'd0);
        chk("rst_load_r", 70'(MEM_WB_bus[63:32]), 70'd0);
        set_bus(1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_2222, 32'h200, 5'd0, 32'h1010);
        #1 chk("rst_store_gated", 70'(dm_wen), 70'd0);
        set_bus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 5'd9, 32'h1010);
        tick();
        resetn = 1'b1;
        #1 chk("rst_over_c0", 70'(MEM_over), 70'd0);
        tick();
        #1 chk("rst_over_c1", 70'(MEM_over), 70'd0);
        tick();
        #1 chk("rst_over_c2", 70'(MEM_over), 70'd1);
        chk("rst_result", 70'(MEM_WB_bus[63:32]), 70'hCAFE_550D);
        tick();
        retire();
        chk("rst_no_write", 70'(wr_cnt - w0), 70'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
